// File: rtl/alu_issue_ctrl.sv
// Issue front end for the combinational ALU. It registers one request at a time into the ALU,
// waits a fixed settle time, captures the result and returns it over a valid/ready response port.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  output logic [4:0]       OP,
  output logic [7:0]       inOne,
  output logic [7:0]       inTwo,
  input  logic [7:0]       res,
  input  logic             ZERO,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_res,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] zero_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

  state_t           state_reg, state_next;
  logic [3:0]       wait_reg, wait_next;
  logic [4:0]       op_reg, op_next;
  logic [7:0]       a_reg, a_next;
  logic [7:0]       b_reg, b_next;
  logic [7:0]       res_reg, res_next;
  logic             zero_reg, zero_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] issue_reg, issue_next;
  logic [CNT_W-1:0] zcnt_reg, zcnt_next;
  logic             accept;
  logic             legal;

  always_comb begin
    legal = 1'b0;
    case (req_op) inside
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01111, 5'b100??: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    zero_next  = zero_reg;
    err_next   = err_reg;
    issue_next = issue_reg;
    zcnt_next  = zcnt_reg;

    req_ready = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    accept    = req_valid && req_ready;

    case (state_reg)
      EXEC: begin
        if (wait_reg != 4'd0) begin
          wait_next = wait_reg - 4'd1;
        end else begin
          res_next   = res;
          zero_next  = ZERO;
          err_next   = 1'b0;
          state_next = RESP;
          if (ZERO && (zcnt_reg != {CNT_W{1'b1}}))
            zcnt_next = zcnt_reg + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready)
          state_next = IDLE;
      end
      default: ;
    endcase

    // A request taken in RESP overrides the return to IDLE, giving back-to-back issue.
    if (accept) begin
      if (legal) begin
        op_next    = req_op;
        a_next     = req_a;
        b_next     = req_b;
        wait_next  = WAIT_INIT;
        state_next = EXEC;
        if (issue_reg != {CNT_W{1'b1}})
          issue_next = issue_reg + CNT_W'(1);
      end else begin
        res_next   = 8'd0;
        zero_next  = 1'b0;
        err_next   = 1'b1;
        state_next = RESP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      wait_reg  <= 4'd0;
      op_reg    <= 5'd0;
      a_reg     <= 8'd0;
      b_reg     <= 8'd0;
      res_reg   <= 8'd0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
      issue_reg <= '0;
      zcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      zero_reg  <= zero_next;
      err_reg   <= err_next;
      issue_reg <= issue_next;
      zcnt_reg  <= zcnt_next;
    end
  end

  assign OP          = op_reg;
  assign inOne       = a_reg;
  assign inTwo       = b_reg;
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_res     = res_reg;
  assign rsp_zero    = zero_reg;
  assign rsp_err     = err_reg;
  assign issue_count = issue_reg;
  assign zero_count  = zcnt_reg;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front end that drives the combinational ALU. It accepts one operation at a time over a valid/ready request port and registers OP/inOne/inTwo into the ALU. After a fixed settle time it captures res/ZERO and returns them over a valid/ready response port. It sits between the decode stage and the ALU, screens out illegal opcodes, and keeps saturating issue and zero-result counters for debug.

Parameters:
ALU_LAT, 1, cycles the ALU inputs are held before res/ZERO are captured (legal range 1..15)
CNT_W, 16, width of the issue_count and zero_count counters

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_op  input  5  ALU opcode
req_a  input  8  operand to inOne
req_b  input  8  operand to inTwo
OP  output  5  registered opcode to the ALU
inOne  output  8  registered operand A to the ALU
inTwo  output  8  registered operand B to the ALU
res  input  8  ALU result (combinational from OP/inOne/inTwo)
ZERO  input  1  ALU zero flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_res  output  8  captured result
rsp_zero  output  1  captured ZERO
rsp_err  output  1  request carried an illegal opcode
issue_count  output  CNT_W  legal ops issued to the ALU, saturating
zero_count  output  CNT_W  issued ops whose captured ZERO was 1, saturating

Behaviour:
- Clock and reset: one clock, CLK. Reset is RESET, synchronous and active-high, and wins over every other event in the same cycle.
- Reset values: state=IDLE; OP=5'b00000; inOne=0; inTwo=0; rsp_valid=0; rsp_res=0; rsp_zero=0; rsp_err=0; both counters=0; internal wait counter=0.
- Legal opcodes: 00000, 00001, 00010, 00011, 00111, 01000, 01001, 01010, 01011, 01100, 01111, and 100xx (any code with OP[4:2]=100, i.e. ADDI). Every other code is illegal.
- States: IDLE, EXEC, RESP.
- req_ready is combinational: 1 in IDLE; 1 in RESP while rsp_ready=1; 0 otherwise. A request is accepted on a rising edge where req_valid and req_ready are both 1.
- Accept of a legal op:
  - OP/inOne/inTwo load req_op/req_a/req_b; wait counter is set to ALU_LAT-1; next state is EXEC.
  - issue_count increments at the same edge, saturating at all-ones.
- Accept of an illegal op:
  - OP/inOne/inTwo are unchanged; next state is RESP.
  - rsp_err=1, rsp_res=0, rsp_zero=0; no counter changes.
- EXEC:
  - While the wait counter is nonzero, it decrements each cycle.
  - When it is 0, the next edge captures rsp_res<=res and rsp_zero<=ZERO, sets rsp_err<=0, and goes to RESP.
  - zero_count increments at that edge if ZERO=1, saturating.
- Latency: rsp_valid rises exactly ALU_LAT cycles after the accept edge for a legal op, and 0 cycles after it for an illegal op (rsp_valid is set at the accept edge).
- RESP: rsp_valid=1. rsp_res, rsp_zero and rsp_err are held stable until the handshake (rsp_valid=1 and rsp_ready=1).
  - On handshake with no new request accepted: go to IDLE; rsp_valid=0 next cycle.
  - On handshake with a request accepted in the same cycle: the new request is processed exactly as from IDLE (back-to-back, no bubble).
- OP/inOne/inTwo hold their last issued values in IDLE and RESP; the ALU is never re-driven without an accepted legal request.
- Reset mid-EXEC or mid-RESP: the in-flight response is dropped and all outputs take their reset values at that edge.
- req_* inputs are ignored whenever req_ready=0.

Test Plan:
- Accept ADD (00000), a=1, b=2; rsp_ready=1; ALU_LAT=1 -> OP=0, inOne=1, inTwo=2 after the accept edge; rsp_valid rises 1 cycle later with rsp_res=3, rsp_zero=0, rsp_err=0; issue_count=1.
- SUB (00001), a=2, b=2 -> rsp_res=0, rsp_zero=1, zero_count=1. Then SEQ (01100), a=5, b=2 -> rsp_zero per ALU result; zero_count changes only if ZERO=1.
- Illegal op 00100, a=7, b=7 -> rsp_valid at the accept edge with rsp_err=1, rsp_res=0; OP/inOne/inTwo keep their prior values; issue_count unchanged.
- SLL (00010), a=1, b=2 with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_res=4 and rsp_zero held stable; req_ready=0 throughout; on the rsp_ready=1 cycle a pending ADDI (10011) is accepted the same cycle.
- ALU_LAT=3 with SRL (00011), a=8, b=2 -> rsp_valid rises exactly 3 cycles after accept with rsp_res=2. Assert RESET during EXEC of a second op -> no response issued; all outputs at reset values next cycle.
- CNT_W=2: issue 5 legal ops -> issue_count saturates at 3. 12 back-to-back ops with rsp_ready=1 -> one accept every ALU_LAT+1 cycles, no lost or duplicated responses.
